debam_seq_mult: RTL and testbench

DEBAM_SEQ_MULT -- requirements
Module: debam_seq_mult

---
 rtl/debam_pkg.sv | 18 +
 rtl/debam_row_gen.sv | 32 +++
 rtl/debam_seq_mult.sv | 126 ++++++++++++
 tb/tb_debam_seq_mult.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/debam_pkg.sv
// rtl/debam_pkg.sv - shared types and constants for the sequential radix-4 multiplier
package debam_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    localparam logic [1:0] DK_ZERO  = 2'b00;
    localparam logic [1:0] DK_ONE   = 2'b01;
    localparam logic [1:0] DK_TWO   = 2'b10;
    localparam logic [1:0] DK_THREE = 2'b11;

endpackage

// File: rtl/debam_row_gen.sv
// rtl/debam_row_gen.sv - radix-4 partial-product row generator with approximate 3A
module debam_row_gen
    import debam_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [1:0]   dk,
    input  logic         approx_en,
    output logic [N+1:0] row
);

    // Row is two bits wider than A: the exact 3A term needs N+2 bits.
    // The approximate 3A replaces the carry chain with A|(A<<1).
    always_comb begin
        row = '0;
        case (dk)
            DK_ZERO:  row = '0;
            DK_ONE:   row = {2'b00, a};
            DK_TWO:   row = {1'b0, a, 1'b0};
            DK_THREE: begin
                if (approx_en) begin
                    row = {1'b0, a, 1'b0} | {2'b00, a};
                end else begin
                    row = {1'b0, a, 1'b0} + {2'b00, a};
                end
            end
            default:  row = '0;
        endcase
    end

endmodule

// File: rtl/debam_seq_mult.sv
// rtl/debam_seq_mult.sv - sequential radix-4 multiplier with approximate low rows and early exit
module debam_seq_mult
    import debam_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int KW  = $clog2(N / 2);
    localparam int TKW = KW + 2;
    localparam logic [TKW-1:0] APPROX_LIM = TKW'(N - M);
    localparam logic [KW-1:0]  K_LAST     = KW'(N / 2 - 1);

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic           mode_r;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] row_shift;
    logic [KW-1:0]  k;
    logic [TKW-1:0] two_k;
    logic [N-1:0]   b_shift;
    logic [N-1:0]   b_rest;
    logic [1:0]     dk;
    logic           approx_en;
    logic           last_row;
    logic           accept;
    logic [N+1:0]   row;

    debam_row_gen #(.N(N)) u_row_gen (
        .a         (a_r),
        .dk        (dk),
        .approx_en (approx_en),
        .row       (row)
    );

    // Current digit, early-exit test and the next accumulator value
    always_comb begin
        two_k     = {1'b0, k, 1'b0};
        b_shift   = b_r >> two_k;
        dk        = b_shift[1:0];
        b_rest    = b_shift >> 2;
        last_row  = (b_rest == '0) || (k == K_LAST);
        approx_en = (mode_r == MODE_APPROX) && (two_k < APPROX_LIM);
        row_shift = {{(N-2){1'b0}}, row} << two_k;
        acc_next  = acc + row_shift;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, row accumulation and result latch; product only changes on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            mode_r  <= MODE_APPROX;
            acc     <= '0;
            k       <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                a_r    <= a;
                b_r    <= b;
                mode_r <= mode;
                acc    <= '0;
                k      <= '0;
            end else if (state == CALC) begin
                acc <= acc_next;
                k   <= k + 1'b1;
                if (last_row) begin
                    product <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_debam_seq_mult.sv
// tb/tb_debam_seq_mult.sv - directed self-checking bench for debam_seq_mult
module tb_debam_seq_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int checks;
    int errors;

    debam_seq_mult #(.N(16), .M(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for out_valid after an accept edge; returns cycles counted
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tm, input logic [31:0] exp_p, input int exp_lat);
        int lat;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        mode     = tm;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hdead;
        b        = 16'hbeef;
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " product"}, 64'(product), 64'(exp_p));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after handoff"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready after handoff"}, 64'(in_ready), 64'd1);
        check({tag, " product held"}, 64'(product), 64'(exp_p));
    endtask

    initial begin
        int lat;
        int seen;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        mode      = 1'b0;
        out_ready = 1'b0;

        #2;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset product", 64'(product), 64'd0);

        // Release mid-cycle; the first edge afterwards must accept
        #5;
        rst_n = 1'b1;
        do_op("first_after_reset approx 1234*1", 16'h1234, 16'h0001, 1'b0, 32'h0000_1234, 1);
        do_op("exact 1234*1",        16'h1234, 16'h0001, 1'b1, 32'h0000_1234, 1);
        do_op("approx b=0",          16'h1234, 16'h0000, 1'b0, 32'h0000_0000, 1);
        do_op("exact b=0",           16'h1234, 16'h0000, 1'b1, 32'h0000_0000, 1);
        do_op("exact ffff*ffff",     16'hffff, 16'hffff, 1'b1, 32'hfffe_0001, 8);
        do_op("approx 3*3",          16'h0003, 16'h0003, 1'b0, 32'h0000_0007, 1);
        do_op("exact 3*3",           16'h0003, 16'h0003, 1'b1, 32'h0000_0009, 1);
        do_op("approx 1*f000",       16'h0001, 16'hf000, 1'b0, 32'h0000_f000, 8);
        do_op("approx 3*30",         16'h0003, 16'h0030, 1'b0, 32'h0000_0070, 3);
        do_op("exact 3*30",          16'h0003, 16'h0030, 1'b1, 32'h0000_0090, 3);
        do_op("exact 2*4000",        16'h0002, 16'h4000, 1'b1, 32'h0000_8000, 8);
        do_op("approx 00ff*3",       16'h00ff, 16'h0003, 1'b0, 32'h0000_01ff, 1);

        // Backpressure: product held while new operands wait outside IDLE
        in_valid = 1'b1;
        a        = 16'h0010;
        b        = 16'h0010;
        mode     = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0007;
        b = 16'h0005;
        wait_done(lat);
        check("bp latency", 64'(lat), 64'd3);
        check("bp product", 64'(product), 64'h100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold product %0d", i), 64'(product), 64'h100);
            check($sformatf("bp hold in_ready %0d", i), 64'(in_ready), 64'd0);
            check($sformatf("bp hold out_valid %0d", i), 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle in_ready", 64'(in_ready), 64'd1);
        check("bp idle product", 64'(product), 64'h100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(lat);
        check("bp second latency", 64'(lat), 64'd2);
        check("bp second product", 64'(product), 64'h23);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset pulse during CALC cycle 3 of a long operation
        in_valid = 1'b1;
        a        = 16'hffff;
        b        = 16'hffff;
        mode     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset in_ready", 64'(in_ready), 64'd1);
        check("mid reset out_valid", 64'(out_valid), 64'd0);
        check("mid reset product", 64'(product), 64'd0);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("abandoned op out_valid count", 64'(seen), 64'd0);
        check("abandoned op in_ready", 64'(in_ready), 64'd1);

        do_op("post reset approx 3*3", 16'h0003, 16'h0003, 1'b0, 32'h0000_0007, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
